// File: rtl/miriscv_alu_issue.sv
// -----------------------------------------------------------------------------
// miriscv_alu_issue
//
// Decode-to-execute issue stage. Takes one RV32I instruction per cycle from
// fetch (together with its register-file read data), decodes it into an ALU
// opcode plus operand pair, writeback control and branch/jump target, and
// holds the result in registers that feed the execute stage through a
// valid/ready handshake.
//
// Configuration macro: MIRISCV_ALU_ISSUE_SKID_EN
//   defined     : main register plus one skid entry (holds 2 instructions);
//                 instr_ready_o is registered ("skid entry empty").
//   not defined : single main register; instr_ready_o = ex_ready_i | ~ex_valid_o.
//
// Ports
//   clk_i, arstn_i                 clock, asynchronous active-low reset
//   instr_i, instr_pc_i            instruction word and its PC
//   instr_valid_i / instr_ready_o  fetch-side handshake
//   rs1_addr_o, rs2_addr_o         register-file read addresses (combinational)
//   rs1_data_i, rs2_data_i         register-file read data (same cycle)
//   flush_i                        kill held and incoming instructions
//   ex_valid_o / ex_ready_i        execute-side handshake
//   alu_port_a_o, alu_port_b_o     ALU operands
//   alu_op_o                       ALU opcode
//   rd_addr_o, rd_we_o             destination register and write enable
//   is_branch_o, is_jump_o         conditional branch / JAL-JALR markers
//   target_o                       branch or jump target
//   illegal_o                      unsupported encoding
// -----------------------------------------------------------------------------

package miriscv_pkg;
    parameter int XLEN = 32;
endpackage

package miriscv_alu_pkg;
    parameter int ALU_OP_WIDTH = 5;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 5'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 5'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 5'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 5'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 5'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 5'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 5'd11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LT   = 5'd12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GE   = 5'd13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 5'd14;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 5'd15;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_JAL  = 5'd16;
endpackage

module miriscv_alu_issue
    import miriscv_pkg::*;
    import miriscv_alu_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic [31:0]             instr_i,
    input  logic [XLEN-1:0]         instr_pc_i,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    output logic [4:0]              rs1_addr_o,
    output logic [4:0]              rs2_addr_o,
    input  logic [XLEN-1:0]         rs1_data_i,
    input  logic [XLEN-1:0]         rs2_data_i,
    input  logic                    flush_i,
    output logic                    ex_valid_o,
    input  logic                    ex_ready_i,
    output logic [XLEN-1:0]         alu_port_a_o,
    output logic [XLEN-1:0]         alu_port_b_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [4:0]              rd_addr_o,
    output logic                    rd_we_o,
    output logic                    is_branch_o,
    output logic                    is_jump_o,
    output logic [XLEN-1:0]         target_o,
    output logic                    illegal_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0]         a;
        logic [XLEN-1:0]         b;
        logic [ALU_OP_WIDTH-1:0] op;
        logic [4:0]              rd;
        logic                    we;
        logic                    is_branch;
        logic                    is_jump;
        logic [XLEN-1:0]         target;
        logic                    illegal;
    } issue_t;

    localparam issue_t PAYLOAD_RST = '{op: ALU_ADD, default: '0};

    // ---------------------------------------------------------------- decode
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_u, imm_b, imm_j;
    logic [XLEN-1:0] pc_plus4, jalr_sum;
    issue_t          dec_next;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_u    = {instr_i[31:12], 12'b0};
    assign imm_b    = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_j    = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign pc_plus4 = instr_pc_i + 32'd4;
    assign jalr_sum = rs1_data_i + imm_i;

    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    always_comb begin
        dec_next    = PAYLOAD_RST;
        dec_next.rd = instr_i[11:7];
        case (opcode)
            OPC_OP: begin
                dec_next.a  = rs1_data_i;
                dec_next.b  = rs2_data_i;
                dec_next.we = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'd0:    dec_next.op = ALU_ADD;
                        3'd1:    dec_next.op = ALU_SLL;
                        3'd2:    dec_next.op = ALU_SLT;
                        3'd3:    dec_next.op = ALU_SLTU;
                        3'd4:    dec_next.op = ALU_XOR;
                        3'd5:    dec_next.op = ALU_SRL;
                        3'd6:    dec_next.op = ALU_OR;
                        default: dec_next.op = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                    dec_next.op = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                    dec_next.op = ALU_SRA;
                end else begin
                    dec_next.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_next.a  = rs1_data_i;
                dec_next.b  = imm_i;
                dec_next.we = 1'b1;
                case (funct3)
                    3'd0: dec_next.op = ALU_ADD;
                    3'd1: begin
                        dec_next.op = ALU_SLL;
                        if (funct7 != 7'b0000000) dec_next.illegal = 1'b1;
                    end
                    3'd2: dec_next.op = ALU_SLT;
                    3'd3: dec_next.op = ALU_SLTU;
                    3'd4: dec_next.op = ALU_XOR;
                    3'd5: begin
                        if (funct7 == 7'b0000000)      dec_next.op = ALU_SRL;
                        else if (funct7 == 7'b0100000) dec_next.op = ALU_SRA;
                        else                           dec_next.illegal = 1'b1;
                    end
                    3'd6:    dec_next.op = ALU_OR;
                    default: dec_next.op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                // ALU_JAL passes port b through, so LUI reuses it with a=0.
                dec_next.op = ALU_JAL;
                dec_next.b  = imm_u;
                dec_next.we = 1'b1;
            end
            OPC_AUIPC: begin
                dec_next.a  = instr_pc_i;
                dec_next.b  = imm_u;
                dec_next.we = 1'b1;
            end
            OPC_JAL: begin
                dec_next.op      = ALU_JAL;
                dec_next.b       = pc_plus4;
                dec_next.target  = instr_pc_i + imm_j;
                dec_next.is_jump = 1'b1;
                dec_next.we      = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'd0) begin
                    dec_next.op      = ALU_JAL;
                    dec_next.b       = pc_plus4;
                    dec_next.target  = {jalr_sum[XLEN-1:1], 1'b0};
                    dec_next.is_jump = 1'b1;
                    dec_next.we      = 1'b1;
                end else begin
                    dec_next.illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                dec_next.a         = rs1_data_i;
                dec_next.b         = rs2_data_i;
                dec_next.target    = instr_pc_i + imm_b;
                dec_next.is_branch = 1'b1;
                case (funct3)
                    3'b000:  dec_next.op = ALU_EQ;
                    3'b001:  dec_next.op = ALU_NE;
                    3'b100:  dec_next.op = ALU_LT;
                    3'b101:  dec_next.op = ALU_GE;
                    3'b110:  dec_next.op = ALU_LTU;
                    3'b111:  dec_next.op = ALU_GEU;
                    default: dec_next.illegal = 1'b1;
                endcase
            end
            default: dec_next.illegal = 1'b1;
        endcase

        // Illegal encodings travel as a harmless ADD 0,0 with no side effects.
        if (dec_next.illegal) begin
            dec_next.a         = '0;
            dec_next.b         = '0;
            dec_next.op        = ALU_ADD;
            dec_next.we        = 1'b0;
            dec_next.is_branch = 1'b0;
            dec_next.is_jump   = 1'b0;
            dec_next.target    = '0;
        end
        if (dec_next.rd == 5'd0) dec_next.we = 1'b0;
    end

    // -------------------------------------------------------------- storage
    logic   main_valid_reg;
    issue_t main_reg;
    logic   main_load;
    logic   accept;

    // Main register may take new data when empty or drained this cycle.
    assign main_load = ~main_valid_reg | ex_ready_i;
    assign accept    = instr_valid_i & instr_ready_o & ~flush_i;

`ifdef MIRISCV_ALU_ISSUE_SKID_EN
    logic   skid_valid_reg;
    issue_t skid_reg;

    assign instr_ready_o = ~skid_valid_reg;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            main_valid_reg <= 1'b0;
            main_reg       <= PAYLOAD_RST;
            skid_valid_reg <= 1'b0;
            skid_reg       <= PAYLOAD_RST;
        end else if (flush_i) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (main_load) begin
            // Skid is only occupied while main is full, and fetch is blocked
            // while skid is occupied, so at most one of these paths loads main.
            if (skid_valid_reg) begin
                main_reg       <= skid_reg;
                main_valid_reg <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else begin
                main_valid_reg <= accept;
                if (accept) main_reg <= dec_next;
            end
        end else if (accept) begin
            skid_reg       <= dec_next;
            skid_valid_reg <= 1'b1;
        end
    end
`else
    assign instr_ready_o = ex_ready_i | ~main_valid_reg;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            main_valid_reg <= 1'b0;
            main_reg       <= PAYLOAD_RST;
        end else if (flush_i) begin
            main_valid_reg <= 1'b0;
        end else if (main_load) begin
            main_valid_reg <= accept;
            if (accept) main_reg <= dec_next;
        end
    end
`endif

    assign ex_valid_o   = main_valid_reg;
    assign alu_port_a_o = main_reg.a;
    assign alu_port_b_o = main_reg.b;
    assign alu_op_o     = main_reg.op;
    assign rd_addr_o    = main_reg.rd;
    assign rd_we_o      = main_reg.we;
    assign is_branch_o  = main_reg.is_branch;
    assign is_jump_o    = main_reg.is_jump;
    assign target_o     = main_reg.target;
    assign illegal_o    = main_reg.illegal;

endmodule
